// File: rtl/ap_pkg.sv
// ap_pkg: opcodes and sequencer states shared by the associative-processor word array.
package ap_pkg;
  localparam logic [2:0] AP_OP_LOAD  = 3'd1;
  localparam logic [2:0] AP_OP_CMP   = 3'd2;
  localparam logic [2:0] AP_OP_WRITE = 3'd3;
  localparam logic [2:0] AP_OP_FLIP  = 3'd4;
  localparam logic [2:0] AP_OP_ABS   = 3'd5;
  localparam logic [2:0] AP_OP_READ  = 3'd6;
  typedef enum logic [1:0] {IDLE, EXEC, ABS_RUN, DONE} ap_state_e;
endpackage

// File: rtl/ap_word_row.sv
// ap_word_row: one storage word with its tag and abs-carry (seen) flag, operated one bit column at a time.
module ap_word_row #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_In,
  input  logic [IW-1:0] idx,
  input  logic          load,
  input  logic          load_bit,
  input  logic          cmp,
  input  logic          key,
  input  logic          mask,
  input  logic          wr,
  input  logic          wr_val,
  input  logic          flip,
  input  logic          abs_init,
  input  logic          abs_step,
  output logic          bit_out,
  output logic          tag
);
  logic [W-1:0] word;
  logic seen;
  assign bit_out = word[idx];
  // abs negates by flipping every bit above the lowest set bit
  always_ff @(posedge clk or negedge rst_In) begin
    if (!rst_In) begin
      word <= '0;
      tag  <= 1'b0;
      seen <= 1'b0;
    end else begin
      if (load) word[idx] <= load_bit;
      if (wr && tag) word[idx] <= wr_val;
      if ((flip && tag) || (abs_step && tag && seen)) word[idx] <= ~bit_out;
      if (cmp) tag <= mask & (bit_out == key);
      if (abs_init) begin
        tag  <= mask & word[W-1];
        seen <= 1'b0;
      end
      if (abs_step && tag) seen <= seen | bit_out;
    end
  end
endmodule

// File: rtl/ap_word_array.sv
// ap_word_array: bit-serial associative storage array with handshake sequencer and in-place ABS.
// Optional AP_TAG_COUNT_EN builds a registered popcount of the tags on tag_count.
module ap_word_array
  import ap_pkg::*;
#(
  parameter int DATA_DEPTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int COL_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_In,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [COL_W-1:0]              col_sel,
  input  logic                          key,
  input  logic                          wr_val,
  input  logic [DATA_DEPTH-1:0]         row_mask,
  input  logic [DATA_DEPTH-1:0]         load_data,
  output logic [DATA_DEPTH-1:0]         tag_out,
  output logic                          any_tag,
  output logic [DATA_DEPTH-1:0]         col_out,
  output logic                          busy,
  output logic                          done,
  output logic                          cmd_err,
  output logic [$clog2(DATA_DEPTH+1)-1:0] tag_count
);
  localparam int IW  = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int TCW = $clog2(DATA_DEPTH + 1);
  ap_state_e state, state_n;
  logic [2:0] op_q;
  logic [COL_W-1:0] col_q;
  logic key_q, wr_q;
  logic [DATA_DEPTH-1:0] mask_q, data_q, bits;
  logic [IW-1:0] cnt, idx;
  logic accept, is_col_op, bad, ex;
  assign cmd_ready = state == IDLE;
  assign busy      = ~cmd_ready;
  assign done      = state == DONE;
  assign any_tag   = |tag_out;
  assign accept    = cmd_valid & cmd_ready;
  assign is_col_op = op_q inside {AP_OP_LOAD, AP_OP_CMP, AP_OP_WRITE, AP_OP_FLIP, AP_OP_READ};
  assign bad       = is_col_op & (col_q >= COL_W'(DATA_WIDTH));
  assign ex        = (state == EXEC) & ~bad;
  assign idx       = state == ABS_RUN ? cnt : col_q[IW-1:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = cmd_op == AP_OP_ABS ? ABS_RUN : EXEC;
      EXEC:    state_n = DONE;
      ABS_RUN: if (cnt == IW'(DATA_WIDTH - 1)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_In) begin
    if (!rst_In) begin
      state   <= IDLE;
      op_q    <= '0;
      col_q   <= '0;
      key_q   <= 1'b0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      cnt     <= '0;
      cmd_err <= 1'b0;
      col_out <= '0;
    end else begin
      state   <= state_n;
      cmd_err <= (state == EXEC) & bad;
      if (accept) begin
        op_q   <= cmd_op;
        col_q  <= col_sel;
        key_q  <= key;
        wr_q   <= wr_val;
        mask_q <= row_mask;
        data_q <= load_data;
        cnt    <= '0;
      end else if (state == ABS_RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (ex && op_q == AP_OP_READ) col_out <= bits;
    end
  end
  // ABS samples row_mask live at acceptance; CMP uses the latched copy
  for (genvar g = 0; g < DATA_DEPTH; g++) begin : g_row
    ap_word_row #(.W(DATA_WIDTH), .IW(IW)) u_row (
      .clk      (clk),
      .rst_In   (rst_In),
      .idx      (idx),
      .load     (ex && op_q == AP_OP_LOAD && mask_q[g]),
      .load_bit (data_q[g]),
      .cmp      (ex && op_q == AP_OP_CMP),
      .key      (key_q),
      .mask     (cmd_ready ? row_mask[g] : mask_q[g]),
      .wr       (ex && op_q == AP_OP_WRITE),
      .wr_val   (wr_q),
      .flip     (ex && op_q == AP_OP_FLIP),
      .abs_init (accept && cmd_op == AP_OP_ABS),
      .abs_step (state == ABS_RUN),
      .bit_out  (bits[g]),
      .tag      (tag_out[g])
    );
  end
`ifdef AP_TAG_COUNT_EN
  logic [TCW-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_DEPTH; i++) pop = pop + TCW'(tag_out[i]);
  end
  always_ff @(posedge clk or negedge rst_In) begin
    if (!rst_In) tag_count <= '0;
    else tag_count <= pop;
  end
`else
  assign tag_count = '0;
`endif
endmodule

// File: tb/tb_ap_word_array.sv
// tb_ap_word_array: scoreboard bench for ap_word_array (DEPTH=4, WIDTH=4) with directed vectors.
module tb_ap_word_array;
  localparam int D = 4, W = 4, CW = 3, TCW = 3;
  localparam logic [2:0] LD = 3'd1, CMP = 3'd2, WR = 3'd3, FL = 3'd4, ABS = 3'd5, RD = 3'd6;
`ifdef AP_TAG_COUNT_EN
  localparam int TC_ABS = 2, TC_CMP1 = 1;
`else
  localparam int TC_ABS = 0, TC_CMP1 = 0;
`endif
  logic clk = 0, rst_In = 0, cmd_valid = 0, key = 0, wr_val = 0;
  logic [2:0] cmd_op = 0;
  logic [CW-1:0] col_sel = 0;
  logic [D-1:0] row_mask = 0, load_data = 0;
  logic cmd_ready, any_tag, busy, done, cmd_err;
  logic [D-1:0] tag_out, col_out;
  logic [TCW-1:0] tag_count;
  int checks = 0, errors = 0;
  typedef struct {string nm; logic err; logic [3:0] tag; logic [3:0] col;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  ap_word_array #(.DATA_DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_In(rst_In), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .col_sel(col_sel), .key(key), .wr_val(wr_val), .row_mask(row_mask), .load_data(load_data),
    .tag_out(tag_out), .any_tag(any_tag), .col_out(col_out), .busy(busy), .done(done),
    .cmd_err(cmd_err), .tag_count(tag_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst_In) begin
      if (!done) chk("cmd_err outside done", cmd_err, 0);
      else if (q.size() == 0) chk("unexpected done", done, 0);
      else begin
        mon_e = q.pop_front();
        chk({mon_e.nm, " cmd_err"}, cmd_err, mon_e.err);
        chk({mon_e.nm, " tag_out"}, tag_out, mon_e.tag);
        chk({mon_e.nm, " any_tag"}, any_tag, |mon_e.tag);
        chk({mon_e.nm, " col_out"}, col_out, mon_e.col);
      end
    end
  end
  task automatic wait_idle(input string nm, output int busy_n, output int done_at);
    busy_n = 0;
    done_at = 0;
    @(negedge clk);
    while (!cmd_ready && busy_n < 50) begin
      busy_n++;
      if (done && done_at == 0) done_at = busy_n;
      @(negedge clk);
    end
    if (!cmd_ready) chk({nm, " idle timeout"}, cmd_ready, 1);
  endtask
  task automatic send(input logic [2:0] op, input logic [2:0] c, input logic k, input logic v,
                      input logic [3:0] m, input logic [3:0] d, input logic ee, input logic [3:0] et,
                      input logic [3:0] ec, input string nm, output int busy_n, output int done_at);
    int n = 0;
    q.push_back('{nm, ee, et, ec});
    cmd_op = op; col_sel = c; key = k; wr_val = v; row_mask = m; load_data = d; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk({nm, " accept timeout"}, cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0; cmd_op = 0; row_mask = 0; load_data = 0;
    wait_idle(nm, busy_n, done_at);
  endtask
  task automatic go(input logic [2:0] op, input logic [2:0] c, input logic k, input logic v,
                    input logic [3:0] m, input logic [3:0] d, input logic ee, input logic [3:0] et,
                    input logic [3:0] ec, input string nm);
    int b, a;
    send(op, c, k, v, m, d, ee, et, ec, nm, b, a);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b, a, n;
    repeat (2) @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset cmd_err", cmd_err, 0);
    chk("reset tag_out", tag_out, 0);
    chk("reset col_out", col_out, 0);
    chk("reset tag_count", tag_count, 0);
    rst_In = 1;
    @(negedge clk);
    // rows 3, -3, -8, 0
    send(LD, 0, 0, 0, 4'b1111, 4'b0011, 0, 4'b0000, 4'b0000, "load c0", b, a);
    chk("single-op busy cycles", b, 2);
    chk("single-op done position", a, 2);
    go(LD, 1, 0, 0, 4'b1111, 4'b0001, 0, 4'b0000, 4'b0000, "load c1");
    go(LD, 2, 0, 0, 4'b1111, 4'b0010, 0, 4'b0000, 4'b0000, "load c2");
    go(LD, 3, 0, 0, 4'b1111, 4'b0110, 0, 4'b0000, 4'b0000, "load c3");
    send(ABS, 0, 0, 0, 4'b1111, 4'b0000, 0, 4'b0110, 4'b0000, "abs1", b, a);
    chk("abs busy cycles", b, 5);
    chk("abs done position", a, 5);
    chk("tag_count after abs", tag_count, TC_ABS);
    // rows now 3, 3, 8, 0
    go(RD, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0110, 4'b0011, "abs read c0");
    go(RD, 3, 0, 0, 4'b0000, 4'b0000, 0, 4'b0110, 4'b0100, "abs read c3");
    go(RD, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0110, 4'b0011, "abs read c1");
    // rows 3, 5, 4, 6
    go(LD, 0, 0, 0, 4'b1111, 4'b0011, 0, 4'b0110, 4'b0011, "load2 c0");
    go(LD, 1, 0, 0, 4'b1111, 4'b1001, 0, 4'b0110, 4'b0011, "load2 c1");
    go(LD, 2, 0, 0, 4'b1111, 4'b1110, 0, 4'b0110, 4'b0011, "load2 c2");
    go(LD, 3, 0, 0, 4'b1111, 4'b0000, 0, 4'b0110, 4'b0011, "load2 c3");
    go(CMP, 0, 1, 0, 4'b1111, 4'b0000, 0, 4'b0011, 4'b0011, "cmp c0 k1");
    chk("tag_count after cmp", tag_count, TC_ABS);
    go(FL, 2, 0, 0, 4'b0000, 4'b0000, 0, 4'b0011, 4'b0011, "flip c2");
    // rows 7, 1, 4, 6
    go(RD, 2, 0, 0, 4'b0000, 4'b0000, 0, 4'b0011, 4'b1101, "flip read c2");
    // rows 0,1 back to 3, 5
    go(LD, 0, 0, 0, 4'b0011, 4'b0011, 0, 4'b0011, 4'b1101, "load3 c0");
    go(LD, 1, 0, 0, 4'b0011, 4'b0001, 0, 4'b0011, 4'b1101, "load3 c1");
    go(LD, 2, 0, 0, 4'b0011, 4'b0010, 0, 4'b0011, 4'b1101, "load3 c2");
    go(LD, 3, 0, 0, 4'b0011, 4'b0000, 0, 4'b0011, 4'b1101, "load3 c3");
    go(CMP, 0, 1, 0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b1101, "cmp masked");
    chk("tag_count masked cmp", tag_count, TC_CMP1);
    go(WR, 3, 0, 1, 4'b0000, 4'b0000, 0, 4'b0001, 4'b1101, "write c3");
    // rows 11, 5, 4, 6
    go(RD, 3, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, "write read c3");
    go(RD, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0011, "write read c0");
    go(RD, 2, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b1110, "write read c2");
    go(RD, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b1001, "write read c1");
    // ABS with a READ queued behind it on a held cmd_valid; rows become 5, 5, 4, 6
    q.push_back('{"held abs", 1'b0, 4'b0001, 4'b1001});
    q.push_back('{"held read c0", 1'b0, 4'b0001, 4'b0011});
    cmd_op = ABS; col_sel = 0; row_mask = 4'b1111; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_op = RD; col_sel = 0; row_mask = 0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("held valid busy cycles", n, 5);
    @(posedge clk);
    #1 cmd_valid = 0; cmd_op = 0;
    wait_idle("held read", b, a);
    repeat (4) @(negedge clk);
    chk("held queue drained", q.size(), 0);
    // out-of-range columns and no-ops
    go(LD, 7, 0, 0, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0011, "load bad col");
    go(CMP, 4, 0, 0, 4'b1111, 4'b0000, 1, 4'b0001, 4'b0011, "cmp bad col");
    go(RD, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0011, "bad col read c0");
    go(RD, 3, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, "bad col read c3");
    go(RD, 5, 0, 0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, "read bad col");
    go(3'd0, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, "noop 0");
    go(3'd7, 7, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, "noop 7");
    // row 3 becomes -2, then reset lands in the second ABS cycle
    go(LD, 3, 0, 0, 4'b1000, 4'b1000, 0, 4'b0001, 4'b0000, "load neg");
    cmd_op = ABS; row_mask = 4'b1111; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0; cmd_op = 0; row_mask = 0;
    chk("abs tag before reset", tag_out, 4'b1000);
    @(posedge clk);
    #2 rst_In = 0;
    #1;
    chk("async reset tag_out", tag_out, 0);
    chk("async reset any_tag", any_tag, 0);
    chk("async reset col_out", col_out, 0);
    chk("async reset done", done, 0);
    chk("async reset cmd_err", cmd_err, 0);
    chk("async reset busy", busy, 0);
    chk("async reset tag_count", tag_count, 0);
    @(negedge clk);
    rst_In = 1;
    @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1);
    go(LD, 0, 0, 0, 4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, "post reset load");
    go(RD, 3, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, "post reset read c3");
    go(RD, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, "post reset read c0");
    repeat (3) @(negedge clk);
    chk("final queue empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
